// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the future receiver.
//   uart_state_t : frame-level state of a serial byte engine
//   DATA_BITS    : payload bits per frame
//   LINE_IDLE    : level of the serial line between frames
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-interval timer: counts 0..CLKS_PER_BIT-1 and wraps.
//   clk      : system clock
//   rst      : synchronous active-high reset, counter to 0
//   restart  : reload the counter to 0 on the next edge (state entry)
//   bit_done : high on the terminal count of the current bit period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done = (cnt_q == LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter (8 data bits, LSB first, 1 or 2 stop bits).
// Bytes enter a one-entry holding register over valid/ready and are
// serialised on txd at CLKS_PER_BIT clocks per bit.
//   clk      : system clock
//   rst      : synchronous active-high reset, aborts any frame
//   tx_data  : byte to send, taken when tx_valid && tx_ready
//   tx_valid : tx_data is valid
//   tx_ready : holding register empty (forced low during reset)
//   tx_busy  : a frame (start/data/stop) is on the line
//   txd      : serial line, idle high
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 txd
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 accept;
  logic                 load;
  logic                 bit_done;
  logic                 restart;

  assign tx_ready = !hold_full_q && !rst;
  assign accept   = tx_valid && tx_ready;
  assign tx_busy  = (state_q != IDLE);

  // Every state change is a state entry, so the bit period restarts there.
  assign restart = (state_d != state_q);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    load        = 1'b0;
    txd         = LINE_IDLE;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        txd = shift_q[0];
        if (bit_done) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        txd = LINE_IDLE;
        if (bit_done) begin
          if (stop_cnt_q == STOP_LAST) begin
            // Chain straight into the next start bit when a byte is waiting.
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end
    // A new byte wins over the load-clear so nothing is dropped.
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
    end
  end

  // Payload registers are qualified by hold_full_q / state_q, so no reset.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
module tb_uart_byte_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic       r1, b1, t1, r2, b2, t2;

  uart_byte_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1),
    .tx_ready(r1), .tx_busy(b1), .txd(t1));

  uart_byte_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2),
    .tx_ready(r2), .tx_busy(b2), .txd(t2));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // Index k: 0 -> one stop bit, 1 -> two stop bits.
  int         m_act[2]  = '{0, 0};
  int         m_t[2]    = '{0, 0};
  int         m_full[2] = '{0, 0};
  logic [7:0] m_byte[2] = '{8'h00, 8'h00};
  logic [7:0] m_hold[2] = '{8'h00, 8'h00};

  function automatic int frame_bit(input logic [7:0] b, input int t);
    int slot;
    slot = t / CPB;
    if (slot == 0) return 0;
    if (slot <= 8) return int'(b[slot-1]);
    return 1;
  endfunction

  task automatic model_step(input int k, input logic v, input logic [7:0] d);
    int len;
    bit acc;
    len = (10 + k) * CPB;
    if (rst) begin
      m_act[k]  = 0;
      m_full[k] = 0;
    end else begin
      acc = v && (m_full[k] == 0);
      if (m_act[k] != 0) begin
        m_t[k]++;
        if (m_t[k] == len) m_act[k] = 0;
      end
      if (m_act[k] == 0 && m_full[k] != 0) begin
        m_act[k]  = 1;
        m_t[k]    = 0;
        m_byte[k] = m_hold[k];
        m_full[k] = 0;
      end
      if (acc) begin
        m_full[k] = 1;
        m_hold[k] = d;
      end
    end
  endtask

  function automatic int exp_vec(input int k);
    int tx;
    int rdy;
    tx  = (m_act[k] != 0) ? frame_bit(m_byte[k], m_t[k]) : 1;
    rdy = (m_full[k] == 0 && rst == 1'b0) ? 1 : 0;
    return tx * 4 + m_act[k] * 2 + rdy;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step(0, v1, d1);
    model_step(1, v2, d2);
  end

  // ---------------- per-cycle compare + busy-run monitor ----------------
  int run_cur[2]  = '{0, 0};
  int run_last[2] = '{0, 0};

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk($sformatf("c%0d dut1 {txd,busy,ready}", cyc), int'({t1, b1, r1}), exp_vec(0));
      chk($sformatf("c%0d dut2 {txd,busy,ready}", cyc), int'({t2, b2, r2}), exp_vec(1));
    end
    if (b1) run_cur[0]++; else if (run_cur[0] > 0) begin run_last[0] = run_cur[0]; run_cur[0] = 0; end
    if (b2) run_cur[1]++; else if (run_cur[1] > 0) begin run_last[1] = run_cur[1]; run_cur[1] = 0; end
  end

  // ---------------- simple receiver on dut1 line ----------------
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh  = 8'h00;
  logic [7:0] rxq[$];

  initial forever begin
    @(negedge clk);
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (t1 == 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
        rx_sh[rx_cnt / CPB - 1] = t1;
      if (rx_cnt == 10 * CPB - 1) begin
        rxq.push_back(rx_sh);
        rx_act = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit tx_log[128];
  bit busy_log[128];

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int k, input logic [7:0] b, input bit drop, output int acc_cyc);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    acc_cyc = 0;
    if (k == 0) begin v1 = 1'b1; d1 = b; end
    else        begin v2 = 1'b1; d2 = b; end
    while (!ok && n < 400) begin
      @(negedge clk);
      ok = (k == 0) ? r1 : r2;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send handshake timeout", 0, 1);
    if (drop) begin
      if (k == 0) v1 = 1'b0; else v2 = 1'b0;
    end
  endtask

  task automatic record(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i]   = (k == 0) ? t1 : t2;
      busy_log[i] = (k == 0) ? b1 : b2;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  bit exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  bit exp_81[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    int a1, a2, a3, lows, ones;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    cycles(2);

    // Reset state
    @(negedge clk);
    chk("reset txd1", int'(t1), 1);
    chk("reset busy1", int'(b1), 0);
    chk("reset ready1", int'(r1), 0);
    chk("reset txd2", int'(t2), 1);
    chk("reset ready2", int'(r2), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready1 after reset", int'(r1), 1);
    chk("ready2 after reset", int'(r2), 1);
    @(posedge clk);
    #1;
    cycles(3);

    // Test 1: 0xA5 from idle
    send(0, 8'hA5, 1'b1, a1);
    record(0, 60);
    chk("t1 idle cycle after accept", int'(busy_log[0]), 0);
    chk("t1 busy from accept+2", int'(busy_log[1]), 1);
    for (int s = 0; s < 10; s++)
      chk($sformatf("t1 slot%0d", s), int'(tx_log[1 + 4 * s + 2]), int'(exp_a5[s]));
    chk("t1 txd after frame", int'(tx_log[41]), 1);
    chk("t1 busy after frame", int'(busy_log[41]), 0);
    chk("t1 busy run length", run_last[0], 40);
    cycles(5);

    // Test 2: 0x00 then 0xFF back-to-back
    send(0, 8'h00, 1'b0, a1);
    send(0, 8'hFF, 1'b1, a2);
    record(0, 90);
    chk("t2 last stop of first", int'(tx_log[38]), 1);
    chk("t2 second start", int'(tx_log[39]), 0);
    chk("t2 second start end", int'(tx_log[42]), 0);
    chk("t2 second bit0", int'(tx_log[43]), 1);
    chk("t2 busy run length", run_last[0], 80);
    cycles(5);

    // Test 3: three bytes with valid held
    rxq.delete();
    send(0, 8'h11, 1'b0, a1);
    send(0, 8'h22, 1'b0, a2);
    send(0, 8'h33, 1'b1, a3);
    chk("t3 second accept delay", a2 - a1, 2);
    chk("t3 third accept delay", a3 - a1, 42);
    cycles(100);
    chk("t3 frames received", rxq.size(), 3);
    if (rxq.size() == 3) begin
      chk("t3 byte0", int'(rxq[0]), 32'h11);
      chk("t3 byte1", int'(rxq[1]), 32'h22);
      chk("t3 byte2", int'(rxq[2]), 32'h33);
    end
    cycles(5);

    // Test 4: reset during data bit 3 of 0x5A with 0xC3 held
    rxq.delete();
    send(0, 8'h5A, 1'b0, a1);
    send(0, 8'hC3, 1'b1, a2);
    cycles(16);
    rst = 1'b1;
    @(negedge clk);
    chk("t4 busy before abort", int'(b1), 1);
    chk("t4 data bit3 level", int'(t1), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4 txd after abort", int'(t1), 1);
    chk("t4 busy after abort", int'(b1), 0);
    chk("t4 ready after abort", int'(r1), 1);
    @(posedge clk);
    #1;
    record(0, 80);
    lows = 0;
    for (int i = 0; i < 80; i++) if (!tx_log[i]) lows++;
    chk("t4 line stays idle", lows, 0);
    chk("t4 no frame received", rxq.size(), 0);

    // Test 5: two stop bits, 0x81
    send(1, 8'h81, 1'b1, a1);
    record(1, 60);
    for (int s = 0; s < 11; s++)
      chk($sformatf("t5 slot%0d", s), int'(tx_log[1 + 4 * s + 2]), int'(exp_81[s]));
    ones = 0;
    for (int i = 37; i <= 44; i++) if (tx_log[i]) ones++;
    chk("t5 last 8 high", ones, 8);
    chk("t5 busy after frame", int'(busy_log[45]), 0);
    chk("t5 busy run length", run_last[1], 44);
    cycles(5);

    // Test 6: valid pulsed during reset
    rst = 1'b1;
    v1 = 1'b1; d1 = 8'h77;
    v2 = 1'b1; d2 = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6 txd in reset", int'(t1), 1);
      chk("t6 busy in reset", int'(b1), 0);
      chk("t6 ready in reset", int'(r1), 0);
      @(posedge clk);
      #1;
    end
    v1 = 1'b0;
    v2 = 1'b0;
    rst = 1'b0;
    record(0, 30);
    lows = 0;
    for (int i = 0; i < 30; i++) if (!tx_log[i] || busy_log[i]) lows++;
    chk("t6 nothing sent", lows, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
